// File: rtl/hazard_scheduler.sv
// ----------------------------------------------------------------------------
// hazard_scheduler
// ID-stage stall/flush controller for the 5-stage MIPS pipeline.
// Stalls the front end on load-use hazards and on MDU accesses while the
// multi-cycle mult/div unit is busy. Squashes IF/ID on a taken branch and
// counts stalled cycles.
//
// Parameters:
//   MDU_LAT  cycles the MDU stays busy after a mult/div issues (>= 1)
//   CNT_W    width of the stall performance counter
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous reset, active-high
//   ID_rs_i         rs field of the instruction in ID
//   ID_rt_i         rt field of the instruction in ID
//   ID_uses_rt_i    ID instruction reads rt as a source
//   ID_mdu_start_i  ID instruction is mult/multu/div/divu
//   ID_mdu_read_i   ID instruction is mfhi/mflo
//   EX_MemRead_i    EX instruction is a load
//   EX_target_i     destination register of the EX instruction
//   branch_taken_i  branch/jump in ID resolved taken
//   PC_write_o      PC register enable
//   IFID_write_o    IF/ID register enable
//   IFID_flush_o    zero IF/ID on the next edge
//   IDEX_bubble_o   load NOP controls into ID/EX
//   mdu_busy_o      MDU occupied
//   stall_cause_o   {mdu, load-use} stall reasons
//   stall_cnt_o     stalled cycles since reset (saturating)
//
// All outputs are combinational from the inputs and the registered state so
// the pipeline can act on them in the same cycle.
// ----------------------------------------------------------------------------
module hazard_scheduler #(
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_rs_i,
    input  logic [4:0]       ID_rt_i,
    input  logic             ID_uses_rt_i,
    input  logic             ID_mdu_start_i,
    input  logic             ID_mdu_read_i,
    input  logic             EX_MemRead_i,
    input  logic [4:0]       EX_target_i,
    input  logic             branch_taken_i,
    output logic             PC_write_o,
    output logic             IFID_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_bubble_o,
    output logic             mdu_busy_o,
    output logic [1:0]       stall_cause_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned MDU_W = $clog2(MDU_LAT + 1);
    localparam logic [MDU_W-1:0] MDU_LOAD = MDU_W'(MDU_LAT);

    logic [MDU_W-1:0] mdu_cnt;
    logic [CNT_W-1:0] stall_cnt;

    logic target_nz;
    logic rs_match;
    logic rt_match;
    logic lu;
    logic md;
    logic stall;
    logic mdu_busy;
    logic mdu_access;
    logic issue;
    logic cnt_sat;

    // Hazard detection; $0 is hardwired so a load into it never conflicts.
    always_comb begin
        target_nz  = (EX_target_i != 5'd0);
        rs_match   = (EX_target_i == ID_rs_i);
        rt_match   = ID_uses_rt_i && (EX_target_i == ID_rt_i);
        lu         = EX_MemRead_i && target_nz && (rs_match || rt_match);
        mdu_busy   = (mdu_cnt != '0);
        mdu_access = ID_mdu_start_i || ID_mdu_read_i;
        md         = mdu_busy && mdu_access;
        stall      = lu || md;
        issue      = ID_mdu_start_i && !stall;
        cnt_sat    = &stall_cnt;
    end

    // Output decode; reset forces a safe, fully-stalled front end.
    always_comb begin
        PC_write_o    = 1'b0;
        IFID_write_o  = 1'b0;
        IFID_flush_o  = 1'b1;
        IDEX_bubble_o = 1'b1;
        mdu_busy_o    = 1'b0;
        stall_cause_o = 2'b00;
        if (!rst_i) begin
            PC_write_o    = !stall;
            IFID_write_o  = !stall;
            // Stall wins over flush: the branch stays in ID and re-resolves.
            IFID_flush_o  = branch_taken_i && !stall;
            IDEX_bubble_o = stall;
            mdu_busy_o    = mdu_busy;
            stall_cause_o = {md, lu};
        end
    end

    assign stall_cnt_o = stall_cnt;

    // MDU occupancy countdown; reset aborts an operation in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mdu_cnt <= '0;
        end else if (issue) begin
            mdu_cnt <= MDU_LOAD;
        end else if (mdu_busy) begin
            mdu_cnt <= mdu_cnt - MDU_W'(1);
        end
    end

    // Saturating stall-cycle performance counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (stall && !cnt_sat) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// ----------------------------------------------------------------------------
// tb_hazard_scheduler
// Self-checking bench for hazard_scheduler (MDU_LAT=4, CNT_W=4). Expected
// outputs come from a cycle-stamped reference model: an MDU issue at cycle t
// marks cycles t+1..t+MDU_LAT busy, and the stall counter is a saturating
// integer.
// ----------------------------------------------------------------------------
module tb_hazard_scheduler;

    localparam int unsigned LAT   = 4;
    localparam int unsigned CW    = 4;
    localparam int          CMAX  = (1 << CW) - 1;
    localparam int          NEVER = -1000;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic          uses_rt;
    logic          mdu_start;
    logic          mdu_read;
    logic          memread;
    logic [4:0]    target;
    logic          br;

    logic          pc_write;
    logic          ifid_write;
    logic          ifid_flush;
    logic          bubble;
    logic          busy;
    logic [1:0]    cause;
    logic [CW-1:0] cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_cyc   = 0;
    int m_issue = NEVER;
    int m_cnt   = 0;

    logic [10:0] obs;
    logic [10:0] exp;

    hazard_scheduler #(.MDU_LAT(LAT), .CNT_W(CW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ID_rs_i        (rs),
        .ID_rt_i        (rt),
        .ID_uses_rt_i   (uses_rt),
        .ID_mdu_start_i (mdu_start),
        .ID_mdu_read_i  (mdu_read),
        .EX_MemRead_i   (memread),
        .EX_target_i    (target),
        .branch_taken_i (br),
        .PC_write_o     (pc_write),
        .IFID_write_o   (ifid_write),
        .IFID_flush_o   (ifid_flush),
        .IDEX_bubble_o  (bubble),
        .mdu_busy_o     (busy),
        .stall_cause_o  (cause),
        .stall_cnt_o    (cnt)
    );

    always #5 clk = ~clk;

    function automatic logic m_busy();
        return (m_cyc > m_issue) && (m_cyc <= m_issue + int'(LAT));
    endfunction

    function automatic logic m_lu();
        return memread && (target != 5'd0) &&
               ((target == rs) || (uses_rt && (target == rt)));
    endfunction

    function automatic logic m_md();
        return m_busy() && (mdu_start || mdu_read);
    endfunction

    // Expected {pc_write, ifid_write, flush, bubble, busy, cause, cnt}
    function automatic logic [10:0] model_out();
        logic st;
        st = m_lu() || m_md();
        if (rst)
            return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, CW'(m_cnt)};
        return {!st, !st, br && !st, st, m_busy(), m_md(), m_lu(), CW'(m_cnt)};
    endfunction

    function automatic logic [10:0] dut_out();
        return {pc_write, ifid_write, ifid_flush, bubble, busy, cause, cnt};
    endfunction

    task automatic drive(input logic r, input logic [4:0] a_rs, input logic [4:0] a_rt,
                         input logic a_urt, input logic a_ms, input logic a_mr,
                         input logic a_mem, input logic [4:0] a_tgt, input logic a_br);
        rst = r; rs = a_rs; rt = a_rt; uses_rt = a_urt;
        mdu_start = a_ms; mdu_read = a_mr; memread = a_mem; target = a_tgt; br = a_br;
        #1;
    endtask

    // Advance one clock and update the model with the inputs seen at the edge.
    task automatic clock();
        logic st;
        @(posedge clk);
        st = m_lu() || m_md();
        if (rst) begin
            m_issue = NEVER;
            m_cnt   = 0;
        end else begin
            if (st && m_cnt < CMAX) m_cnt++;
            if (mdu_start && !st) m_issue = m_cyc;
        end
        m_cyc++;
        #1;
    endtask

    task automatic reset_dut();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        clock();
        clock();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1);
        clock();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
            obs = dut_out();
            total++;
            if (obs !== 11'b00_1_1_0_00_0000) begin
                bad++;
                $display("FAIL reset_forced[%0d] got=%b exp=%b", i, obs, 11'b00110000000);
            end
            clock();
        end
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        obs = dut_out();
        exp = model_out();
        total++;
        if (obs !== exp || obs !== 11'b11_0_0_0_00_0000) begin
            bad++;
            $display("FAIL reset_release got=%b exp=%b", obs, exp);
        end
    endtask

    task automatic test_load_use();
        reset_dut();
        drive(1'b0, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
        obs = dut_out();
        exp = model_out();
        total++;
        if (obs !== exp || pc_write !== 1'b0 || bubble !== 1'b1 || cause !== 2'b01) begin
            bad++;
            $display("FAIL load_use_stall got=%b exp=%b", obs, exp);
        end
        clock();
        drive(1'b0, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        obs = dut_out();
        exp = model_out();
        total++;
        if (obs !== exp || pc_write !== 1'b1 || cnt !== 4'd1) begin
            bad++;
            $display("FAIL load_use_release got=%b exp=%b", obs, exp);
        end
        clock();
        // rt match only counts when the instruction actually reads rt
        drive(1'b0, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
        obs = dut_out();
        exp = model_out();
        total++;
        if (obs !== exp || cause !== 2'b01) begin
            bad++;
            $display("FAIL load_use_rt got=%b exp=%b", obs, exp);
        end
        clock();
    endtask

    task automatic test_no_hazard();
        reset_dut();
        drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
        obs = dut_out();
        exp = model_out();
        total++;
        if (obs !== exp || pc_write !== 1'b1) begin
            bad++;
            $display("FAIL zero_reg got=%b exp=%b", obs, exp);
        end
        clock();
        drive(1'b0, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0);
        obs = dut_out();
        exp = model_out();
        total++;
        if (obs !== exp || pc_write !== 1'b1) begin
            bad++;
            $display("FAIL rt_unused got=%b exp=%b", obs, exp);
        end
        clock();
    endtask

    task automatic test_mdu();
        reset_dut();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        obs = dut_out();
        exp = model_out();
        total++;
        if (obs !== exp || pc_write !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mdu_issue got=%b exp=%b", obs, exp);
        end
        clock();
        for (int k = 1; k <= int'(LAT); k++) begin
            drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
            obs = dut_out();
            exp = model_out();
            total++;
            if (obs !== exp || cause !== 2'b10 || busy !== 1'b1 || pc_write !== 1'b0) begin
                bad++;
                $display("FAIL mfhi_stall[t+%0d] got=%b exp=%b", k, obs, exp);
            end
            clock();
        end
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        obs = dut_out();
        exp = model_out();
        total++;
        if (obs !== exp || pc_write !== 1'b1 || busy !== 1'b0 || cnt !== 4'd4) begin
            bad++;
            $display("FAIL mfhi_proceed got=%b exp=%b", obs, exp);
        end
        clock();
    endtask

    task automatic test_back_to_back();
        reset_dut();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        clock();
        // Second mult waits in ID, then issues and reloads the counter.
        for (int k = 1; k <= 2 * int'(LAT) + 2; k++) begin
            drive(1'b0, 5'd0, 5'd0, 1'b0, k <= int'(LAT) + 1, 1'b0, 1'b0, 5'd0, 1'b0);
            obs = dut_out();
            exp = model_out();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL b2b[t+%0d] got=%b exp=%b", k, obs, exp);
            end
            clock();
        end
    endtask

    task automatic test_branch();
        reset_dut();
        drive(1'b0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        obs = dut_out();
        exp = model_out();
        total++;
        if (obs !== exp || ifid_flush !== 1'b1) begin
            bad++;
            $display("FAIL branch_flush got=%b exp=%b", obs, exp);
        end
        clock();
        drive(1'b0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1);
        obs = dut_out();
        exp = model_out();
        total++;
        if (obs !== exp || ifid_flush !== 1'b0 || bubble !== 1'b1) begin
            bad++;
            $display("FAIL branch_vs_stall got=%b exp=%b", obs, exp);
        end
        clock();
    endtask

    task automatic test_reset_abort();
        reset_dut();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0);
        clock();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        clock();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        obs = dut_out();
        exp = model_out();
        total++;
        if (obs !== exp || busy !== 1'b0 || ifid_flush !== 1'b1) begin
            bad++;
            $display("FAIL abort_in_reset got=%b exp=%b", obs, exp);
        end
        clock();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        obs = dut_out();
        exp = model_out();
        total++;
        if (obs !== exp || busy !== 1'b0 || cnt !== 4'd0 || pc_write !== 1'b1) begin
            bad++;
            $display("FAIL abort_after got=%b exp=%b", obs, exp);
        end
        clock();
    endtask

    task automatic test_saturation();
        reset_dut();
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0);
            clock();
        end
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        obs = dut_out();
        exp = model_out();
        total++;
        if (obs !== exp || cnt !== 4'd15) begin
            bad++;
            $display("FAIL cnt_saturate got=%0d exp=15", cnt);
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 39) == 0,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 4) == 0);
            obs = dut_out();
            exp = model_out();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL random[%0d] got=%b exp=%b", k, obs, exp);
            end
            clock();
        end
    endtask

    initial begin
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        test_reset();
        test_load_use();
        test_no_hazard();
        test_mdu();
        test_back_to_back();
        test_branch();
        test_reset_abort();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
